// File: rtl/pdm_modulator_if.sv
// Sample producer handshake for pdm_modulator: signed PCM word plus valid/ready.
// The producer side drives pcm_data/pcm_valid; the modulator side returns pcm_ready.
interface pdm_modulator_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (
    output pcm_data,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_data,
    input  pcm_valid,
    output pcm_ready
  );
endinterface

// File: rtl/pdm_modulator.sv
// pdm_modulator: signed PCM to 1-bit PDM via a second-order sigma-delta loop
// with saturating integrators. A one-word buffer decouples the producer; en_pcm
// moves the buffered word into the loop input, en_pdm advances the loop by one bit.
// Optional feature macro: LINEAR_INTERP_EN (linear interpolation of the loop input
// across each sample period instead of zero-order hold).
module pdm_modulator #(
  parameter int WIDTH      = 16,
  parameter int RATIO_LOG2 = 6,
  parameter int ACC_W      = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_pdm,
  input  logic                en_pcm,
  pdm_modulator_if.slave      pcm,
  output logic                pdm_out,
  output logic                underrun
);

  localparam int SUM_W = ACC_W + 2;

  // Integrator clamp limits: symmetric, +/-(2^(ACC_W-1)-1)
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  // Feedback magnitude 2^(WIDTH-1), sign chosen by the previous output bit
  localparam logic signed [SUM_W-1:0] FB_POS =
    {{(SUM_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_NEG = -FB_POS;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[ACC_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic                    pdm_q, pdm_d;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic        [WIDTH-1:0] buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic                    underrun_q, underrun_d;

  logic                    xfer;
  logic signed [WIDTH-1:0] new_sample;
  logic signed [WIDTH-1:0] x;
  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] sum1;
  logic signed [SUM_W-1:0] sum2;
  logic signed [ACC_W-1:0] i1n;
  logic signed [ACC_W-1:0] i2n;

  assign pcm.pcm_ready = ~buf_full_q;
  assign pdm_out       = pdm_q;
  assign underrun      = underrun_q;

  // Sample selection and buffer next state
  always_comb begin
    xfer       = pcm.pcm_valid & ~buf_full_q;
    new_sample = cur_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    underrun_d = 1'b0;
    if (en_pcm) begin
      if (buf_full_q) begin
        new_sample = $signed(buf_q);
        buf_full_d = 1'b0;
      end else if (xfer) begin
        // Bypass: word goes straight into the loop, buffer stays empty
        new_sample = $signed(pcm.pcm_data);
      end else begin
        underrun_d = 1'b1;
      end
    end else if (xfer) begin
      buf_d      = pcm.pcm_data;
      buf_full_d = 1'b1;
    end
    cur_d = en_pcm ? new_sample : cur_q;
  end

`ifdef LINEAR_INTERP_EN
  // cur_q always holds the latest taken sample, so it doubles as the interpolation target
  logic signed [WIDTH+RATIO_LOG2-1:0] xa_q, xa_d;
  logic signed [WIDTH:0]              step_q, step_d;

  // Interpolator: restart from the old target on en_pcm, otherwise ramp one step per PDM bit
  always_comb begin
    xa_d   = xa_q;
    step_d = step_q;
    if (en_pcm) begin
      xa_d   = $signed({cur_q, {RATIO_LOG2{1'b0}}});
      step_d = $signed({new_sample[WIDTH-1], new_sample}) - $signed({cur_q[WIDTH-1], cur_q});
    end else if (en_pdm) begin
      xa_d = xa_q + $signed({{(RATIO_LOG2-1){step_q[WIDTH]}}, step_q});
    end
    x = $signed(xa_q[WIDTH+RATIO_LOG2-1:RATIO_LOG2]);
  end

  // Interpolator state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xa_q   <= '0;
      step_q <= '0;
    end else begin
      xa_q   <= xa_d;
      step_q <= step_d;
    end
  end
`else
  // Zero-order hold: loop input is the current sample
  always_comb begin
    x = cur_q;
  end
`endif

  // Sigma-delta loop step using the pre-update output bit as feedback
  always_comb begin
    fb    = pdm_q ? FB_POS : FB_NEG;
    sum1  = SUM_W'(i1_q) + SUM_W'(x) - fb;
    i1n   = sat(sum1);
    sum2  = SUM_W'(i2_q) + SUM_W'(i1n) - fb;
    i2n   = sat(sum2);
    i1_d  = en_pdm ? i1n : i1_q;
    i2_d  = en_pdm ? i2n : i2_q;
    pdm_d = en_pdm ? ~i2n[ACC_W-1] : pdm_q;
  end

  // Loop, sample and buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q       <= '0;
      i2_q       <= '0;
      pdm_q      <= 1'b0;
      cur_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      pdm_q      <= pdm_d;
      cur_q      <= cur_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: cycle-level arithmetic reference model,
// directed handshake/underrun/reset cases, density checks and randomized traffic.
module tb_pdm_modulator;
  localparam int WIDTH = 16;
  localparam int RL    = 6;
  localparam int ACC_W = 20;
  localparam int R     = 64;
  localparam int FS    = 32768;
  localparam int SATV  = 524287;

  logic clk = 1'b0;
  logic reset;
  logic en_pdm;
  logic en_pcm;
  logic pdm_out;
  logic underrun;

  pdm_modulator_if #(.WIDTH(WIDTH)) pif ();

  pdm_modulator #(.WIDTH(WIDTH), .RATIO_LOG2(RL), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en_pdm   (en_pdm),
    .en_pcm   (en_pcm),
    .pcm      (pif.slave),
    .pdm_out  (pdm_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state (plain integers)
  int m_i1, m_i2, m_cur, m_buf, m_xa, m_step;
  bit m_pdm, m_full, m_under;
  bit last_xfer;
  int ones, m_ones, bits, unders, pdm_cnt;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > SATV) return SATV;
    if (v < -SATV) return -SATV;
    return v;
  endfunction

  function automatic int sx(input logic [WIDTH-1:0] d);
    return int'($signed(d));
  endfunction

  task automatic model_clear();
    m_i1 = 0; m_i2 = 0; m_cur = 0; m_buf = 0; m_xa = 0; m_step = 0;
    m_pdm = 0; m_full = 0; m_under = 0; last_xfer = 0;
  endtask

  // One clock: predict from current inputs, advance, compare
  task automatic tick();
    int x, fb, a, b, nw;
    int n_i1, n_i2, n_buf, n_xa, n_step;
    bit xfer, n_pdm, n_full, n_under;
    xfer = pif.pcm_valid && !m_full;
`ifdef LINEAR_INTERP_EN
    x = m_xa >>> RL;
`else
    x = m_cur;
`endif
    n_i1 = m_i1; n_i2 = m_i2; n_pdm = m_pdm;
    if (en_pdm) begin
      fb = m_pdm ? FS : -FS;
      a = sat(m_i1 + x - fb);
      b = sat(m_i2 + a - fb);
      n_i1 = a; n_i2 = b; n_pdm = (b >= 0);
    end
    n_under = 0; n_full = m_full; n_buf = m_buf; nw = m_cur;
    if (en_pcm) begin
      if (m_full) begin
        nw = m_buf; n_full = 0;
      end else if (xfer) begin
        nw = sx(pif.pcm_data);
      end else begin
        n_under = 1;
      end
    end else if (xfer) begin
      n_buf = sx(pif.pcm_data); n_full = 1;
    end
    n_xa = m_xa; n_step = m_step;
    if (en_pcm) begin
      n_xa = m_cur * R; n_step = nw - m_cur;
    end else if (en_pdm) begin
      n_xa = m_xa + m_step;
    end
    last_xfer = xfer;
    @(posedge clk);
    #1;
    m_i1 = n_i1; m_i2 = n_i2; m_pdm = n_pdm; m_cur = nw; m_buf = n_buf;
    m_full = n_full; m_under = n_under; m_xa = n_xa; m_step = n_step;
    if (en_pdm) begin
      bits++;
      ones   += int'(pdm_out === 1'b1);
      m_ones += int'(m_pdm);
    end
    unders += int'(underrun === 1'b1);
    check_eq("pdm_out", pdm_out, m_pdm);
    check_eq("pcm_ready", pif.pcm_ready, !m_full);
    check_eq("underrun", underrun, m_under);
    check_eq("cur", $signed(dut.cur_q), m_cur);
    check_eq("i1", $signed(dut.i1_q), m_i1);
    check_eq("i2", $signed(dut.i2_q), m_i2);
  endtask

  task automatic clear_counts();
    ones = 0; m_ones = 0; bits = 0; unders = 0;
  endtask

  task automatic do_reset();
    reset = 1; en_pdm = 0; en_pcm = 0; pif.pcm_valid = 0; pif.pcm_data = '0;
    @(posedge clk);
    #1;
    model_clear();
    check_eq("rst_pdm_out", pdm_out, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_ready", pif.pcm_ready, 1);
    check_eq("rst_i1", $signed(dut.i1_q), 0);
    check_eq("rst_i2", $signed(dut.i2_q), 0);
    check_eq("rst_cur", $signed(dut.cur_q), 0);
    reset = 0;
    pdm_cnt = 0;
  endtask

  // Constant producer, one PDM bit per two cycles, en_pcm on an idle cycle every R bits
  task automatic run_bits(input int n, input int sample);
    for (int k = 0; k < n; k++) begin
      pif.pcm_valid = 1; pif.pcm_data = 16'(sample);
      en_pdm = 1; en_pcm = 0;
      tick();
      pdm_cnt++;
      en_pdm = 0; en_pcm = (pdm_cnt % R == 0);
      tick();
    end
    en_pcm = 0;
  endtask

  initial begin
    pdm_cnt = 0;
    clear_counts();
    do_reset();

    // Handshake: two words offered, no en_pcm
    pif.pcm_valid = 1; pif.pcm_data = 16'(1234);
    tick();
    pif.pcm_data = 16'(-2222);
    tick();
    check_eq("hs_ready_low", pif.pcm_ready, 0);
    check_eq("hs_buf_first", $signed(dut.buf_q), 1234);
    en_pcm = 1;
    tick();
    check_eq("hs_cur_first", $signed(dut.cur_q), 1234);
    check_eq("hs_ready_back", pif.pcm_ready, 1);
    en_pcm = 0;
    tick();
    check_eq("hs_buf_second", $signed(dut.buf_q), -2222);
    check_eq("hs_ready_low2", pif.pcm_ready, 0);

    // Underrun and bypass
    pif.pcm_valid = 0; en_pcm = 1;
    tick();
    check_eq("ur_none_when_full", underrun, 0);
    tick();
    check_eq("ur_pulse", underrun, 1);
    check_eq("ur_cur_held", $signed(dut.cur_q), -2222);
    en_pcm = 0;
    tick();
    check_eq("ur_one_cycle", underrun, 0);
    en_pcm = 1; pif.pcm_valid = 1; pif.pcm_data = 16'(777);
    tick();
    check_eq("bypass_cur", $signed(dut.cur_q), 777);
    check_eq("bypass_no_ur", underrun, 0);
    check_eq("bypass_ready", pif.pcm_ready, 1);
    en_pcm = 0; pif.pcm_valid = 0;
    tick();

    // Zero input density
    run_bits(256, 0);
    clear_counts();
    run_bits(1024, 0);
    check_eq("zero_ones_model", ones, m_ones);
    check_eq("zero_ones_range", int'(ones >= 508 && ones <= 516), 1);
    check_eq("zero_no_underrun", unders, 0);

    // DC +0.5 FS and -0.5 FS
    run_bits(128, 16384);
    clear_counts();
    run_bits(4096, 16384);
    check_eq("dc_pos_ones_model", ones, m_ones);
    check_eq("dc_pos_range", int'(ones >= 3031 && ones <= 3113), 1);
    run_bits(128, -16384);
    clear_counts();
    run_bits(4096, -16384);
    check_eq("dc_neg_ones_model", ones, m_ones);
    check_eq("dc_neg_range", int'(ones >= 983 && ones <= 1065), 1);

    // Negative full scale: saturation without wrap, then recovery
    clear_counts();
    run_bits(4096, -32768);
    check_eq("nfs_density", int'(ones <= 81), 1);
    check_eq("nfs_i2_pinned", $signed(dut.i2_q), -SATV);
    run_bits(256, 0);
    clear_counts();
    run_bits(256, 0);
    check_eq("recover_range", int'(ones >= 123 && ones <= 133), 1);

    // Reset mid-stream with a full buffer
    run_bits(40, 5000);
    pif.pcm_valid = 1;
    @(negedge clk);
    reset = 1;
    #1;
    check_eq("mid_rst_i1", $signed(dut.i1_q), 0);
    check_eq("mid_rst_i2", $signed(dut.i2_q), 0);
    check_eq("mid_rst_cur", $signed(dut.cur_q), 0);
    check_eq("mid_rst_pdm", pdm_out, 0);
    check_eq("mid_rst_ready", pif.pcm_ready, 1);
    @(posedge clk);
    #1;
    model_clear();
    reset = 0;
    pif.pcm_valid = 0;
    pdm_cnt = 0;

    // Randomized traffic: random gaps, random producer, some coincident strobes
    for (int k = 0; k < 1500; k++) begin
      bit due, co;
      int gap;
      due = (pdm_cnt % R == R - 1);
      co  = due && ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 2);
      if (due && !co && gap == 0) gap = 1;
      if (last_xfer || !pif.pcm_valid) begin
        pif.pcm_valid = ($urandom_range(0, 3) != 0);
        pif.pcm_data  = 16'($urandom);
      end
      en_pdm = 1; en_pcm = co;
      tick();
      pdm_cnt++;
      for (int g = 0; g < gap; g++) begin
        if (last_xfer || !pif.pcm_valid) begin
          pif.pcm_valid = ($urandom_range(0, 3) != 0);
          pif.pcm_data  = 16'($urandom);
        end
        en_pdm = 0; en_pcm = (g == 0) && due && !co;
        tick();
      end
    end
    en_pdm = 0; en_pcm = 0;

`ifdef LINEAR_INTERP_EN
    // Interpolation ramp 0 -> 6400 over R strobes
    do_reset();
    pif.pcm_valid = 1; pif.pcm_data = 16'(0); en_pcm = 1;
    tick();
    pif.pcm_data = 16'(6400);
    tick();
    en_pcm = 0; pif.pcm_valid = 0;
    for (int k = 1; k <= R; k++) begin
      en_pdm = 1;
      tick();
      check_eq("interp_x", $signed(dut.x), 100 * k);
      en_pdm = 0;
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #5_000_000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule
